bist_pattern_misr: RTL and testbench



---
 rtl/bist_pattern_misr.sv | 115 +++++++++++
 tb/tb_bist_pattern_misr.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bist_pattern_misr.sv
// Built-in self-test engine: drives an 8-bit LFSR pattern stream into a data-path block
// and folds its responses into an 8-bit MISR signature that is checked against a golden value.
module bist_pattern_misr #(
  parameter logic [7:0] SEED = 8'hA5,
  parameter int         NPAT = 256,
  parameter int         LAT  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] golden,
  input  logic [7:0] i_resp,
  output logic [7:0] o_data,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic       pass
);

  generate
    if (SEED == 8'h00) begin : g_bad_seed
      $error("bist_pattern_misr: SEED must be nonzero");
    end
    if (NPAT < 1 || NPAT > 65535) begin : g_bad_npat
      $error("bist_pattern_misr: NPAT out of range 1..65535");
    end
    if (LAT < 0 || LAT > 15) begin : g_bad_lat
      $error("bist_pattern_misr: LAT out of range 0..15");
    end
  endgenerate

  localparam logic [15:0] NPAT_W  = 16'(NPAT);
  localparam logic [15:0] NPAT_M1 = 16'(NPAT - 1);
  localparam logic [3:0]  LAT_W   = 4'(LAT);

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

  state_t      state;
  logic [15:0] pat_cnt;
  logic [15:0] rsp_cnt;
  logic [3:0]  lat_cnt;

  logic        cmp_en;
  logic        last_rsp;
  logic [7:0]  sig_next;

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [7:0] r);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ r;
  endfunction

  // The compaction window opens LAT cycles after DRIVE entry and closes after NPAT samples.
  always_comb begin
    cmp_en   = 1'b0;
    last_rsp = 1'b0;
    sig_next = signature;
    if ((state == DRIVE || state == DRAIN) && lat_cnt == LAT_W && rsp_cnt != NPAT_W) begin
      cmp_en   = 1'b1;
      sig_next = misr_next(signature, i_resp);
      last_rsp = (rsp_cnt == NPAT_M1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_data    <= SEED;
      signature <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      pat_cnt   <= 16'd0;
      rsp_cnt   <= 16'd0;
      lat_cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= DRIVE;
            o_data    <= SEED;
            signature <= 8'h00;
            pass      <= 1'b0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pat_cnt   <= 16'd0;
            rsp_cnt   <= 16'd0;
            lat_cnt   <= 4'd0;
          end
        end
        DRIVE, DRAIN: begin
          o_data    <= lfsr_next(o_data);
          signature <= sig_next;
          if (cmp_en) rsp_cnt <= rsp_cnt + 16'd1;
          if (lat_cnt != LAT_W) lat_cnt <= lat_cnt + 4'd1;
          if (state == DRIVE) begin
            pat_cnt <= pat_cnt + 16'd1;
            if (pat_cnt == NPAT_M1 && LAT != 0) state <= DRAIN;
          end
          // With LAT=0 the final sample lands in the last DRIVE cycle, so DRAIN is skipped.
          if (last_rsp) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == golden);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_pattern_misr.sv
// Bench for bist_pattern_misr: three instances with different NPAT/LAT, a timeline-based
// reference model of each run, and a per-cycle compare of every output.
module tb_bist_pattern_misr;

  logic clk;
  logic rst0, rst1, rst2;
  logic start0, start1, start2;
  logic [7:0] golden0, golden1, golden2;
  logic [7:0] resp0, resp1, resp2;

  logic [7:0] od_v [3];
  logic [7:0] sig_v [3];
  logic       busy_v [3];
  logic       done_v [3];
  logic       pass_v [3];

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  bit rnd_done = 1'b0;

  localparam int NP [3] = '{2, 4, 20};
  localparam int LT [3] = '{0, 1, 3};

  logic [7:0] pat [64];
  int         m_ph  [3];
  int         m_t   [3];
  int         m_odx [3];
  logic [7:0] m_sig [3];
  logic       m_pass [3];

  bist_pattern_misr #(.SEED(8'hA5), .NPAT(2), .LAT(0)) u_a (
    .clk(clk), .rst(rst0), .start(start0), .golden(golden0), .i_resp(resp0),
    .o_data(od_v[0]), .busy(busy_v[0]), .done(done_v[0]), .signature(sig_v[0]), .pass(pass_v[0]));

  bist_pattern_misr #(.SEED(8'hA5), .NPAT(4), .LAT(1)) u_b (
    .clk(clk), .rst(rst1), .start(start1), .golden(golden1), .i_resp(resp1),
    .o_data(od_v[1]), .busy(busy_v[1]), .done(done_v[1]), .signature(sig_v[1]), .pass(pass_v[1]));

  bist_pattern_misr #(.SEED(8'hA5), .NPAT(20), .LAT(3)) u_c (
    .clk(clk), .rst(rst2), .start(start2), .golden(golden2), .i_resp(resp2),
    .o_data(od_v[2]), .busy(busy_v[2]), .done(done_v[2]), .signature(sig_v[2]), .pass(pass_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block under test for instance b: a one-cycle register of the pattern stream.
  always @(posedge clk) resp1 <= od_v[1];

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & 8'hB8)};
  endfunction

  function automatic logic [7:0] misr_step(input logic [7:0] s, input logic [7:0] r);
    return {s[6:0], ^(s & 8'hB8)} ^ r;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_done(input int which, input int maxc, input string nm);
    int n = 0;
    while (done_v[which] !== 1'b1 && n < maxc) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_v[which] !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout actual=done_%0b required=done_1 after %0d cycles", nm, done_v[which], n);
    end
  endtask

  // Reference model: a run is a numbered timeline of NPAT+LAT busy cycles; cycle t shows
  // pattern t-1 and folds the response whenever t-1 >= LAT.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic r, s;
      logic [7:0] g, rv;
      case (i)
        0: begin r = rst0; s = start0; g = golden0; rv = resp0; end
        1: begin r = rst1; s = start1; g = golden1; rv = resp1; end
        default: begin r = rst2; s = start2; g = golden2; rv = resp2; end
      endcase
      if (r) begin
        m_ph[i] = 0; m_t[i] = 0; m_odx[i] = 0; m_sig[i] = 8'h00; m_pass[i] = 1'b0;
      end else if (m_ph[i] != 1) begin
        if (s) begin
          m_ph[i] = 1; m_t[i] = 1; m_odx[i] = 0; m_sig[i] = 8'h00; m_pass[i] = 1'b0;
        end
      end else begin
        if (m_t[i] - 1 >= LT[i]) m_sig[i] = misr_step(m_sig[i], rv);
        m_odx[i] = m_t[i];
        if (m_t[i] == NP[i] + LT[i]) begin
          m_pass[i] = (m_sig[i] == g);
          m_ph[i] = 2;
        end else begin
          m_t[i] = m_t[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("i%0d_o_data", i), od_v[i], pat[m_odx[i]]);
        chk($sformatf("i%0d_busy", i), {7'b0, busy_v[i]}, {7'b0, m_ph[i] == 1});
        chk($sformatf("i%0d_done", i), {7'b0, done_v[i]}, {7'b0, m_ph[i] == 2});
        chk($sformatf("i%0d_signature", i), sig_v[i], m_sig[i]);
        chk($sformatf("i%0d_pass", i), {7'b0, pass_v[i]}, {7'b0, m_pass[i]});
      end
    end
  end

  // Random runs, aborts and responses on instance c.
  initial begin
    rst2 = 1'b1; start2 = 1'b0; golden2 = 8'h00; resp2 = 8'h00;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(negedge clk);
      start2  = ($urandom_range(0, 5) == 0);
      rst2    = ($urandom_range(0, 90) == 0);
      golden2 = 8'($urandom);
      resp2   = 8'($urandom);
    end
    rst2 = 1'b0; start2 = 1'b0;
    rnd_done = 1'b1;
  end

  initial begin
    pat[0] = 8'hA5;
    for (int k = 1; k < 64; k++) pat[k] = lfsr_step(pat[k-1]);
    for (int i = 0; i < 3; i++) begin
      m_ph[i] = 0; m_t[i] = 0; m_odx[i] = 0; m_sig[i] = 8'h00; m_pass[i] = 1'b0;
    end
    rst0 = 1'b1; rst1 = 1'b1; start0 = 1'b0; start1 = 1'b0;
    golden0 = 8'h03; golden1 = 8'h00; resp0 = 8'h01;
    repeat (2) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    chk_on = 1'b1;
    chk("reset_o_data", od_v[1], 8'hA5);
    chk("reset_signature", sig_v[1], 8'h00);
    chk("reset_busy_done", {6'b0, busy_v[1], done_v[1]}, 8'h00);

    // First run on both a and b; b's pattern stream is pinned by hand.
    start0 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    chk("run_busy", {7'b0, busy_v[1]}, 8'h01);
    chk("pat0", od_v[1], 8'hA5);
    @(negedge clk);
    chk("pat1", od_v[1], 8'h4A);
    @(negedge clk);
    chk("pat2", od_v[1], 8'h95);
    wait_done(0, 10, "a_run1");
    chk("a_sig_pass", sig_v[0], 8'h03);
    chk("a_pass_hi", {7'b0, pass_v[0]}, 8'h01);
    wait_done(1, 20, "b_run1");

    // Instance a again with a wrong golden value.
    golden0 = 8'h02;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, 10, "a_run2");
    chk("a_sig_fail", sig_v[0], 8'h03);
    chk("a_pass_lo", {7'b0, pass_v[0]}, 8'h00);

    // Abort b at pattern 2, then a clean rerun that must reproduce the first signature.
    golden1 = m_sig[1];
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (2) @(negedge clk);
    rst1 = 1'b1;
    @(negedge clk);
    rst1 = 1'b0;
    chk("abort_o_data", od_v[1], 8'hA5);
    chk("abort_signature", sig_v[1], 8'h00);
    chk("abort_busy_done", {6'b0, busy_v[1], done_v[1]}, 8'h00);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait_done(1, 20, "b_rerun");
    chk("b_rerun_pass", {7'b0, pass_v[1]}, 8'h01);

    // start held high: one run, one done cycle, then a fresh run.
    start1 = 1'b1;
    @(negedge clk);
    wait_done(1, 20, "b_held");
    @(negedge clk);
    chk("held_restart_busy", {6'b0, busy_v[1], done_v[1]}, 8'h02);
    chk("held_restart_o_data", od_v[1], 8'hA5);
    chk("held_restart_sig", sig_v[1], 8'h00);
    start1 = 1'b0;
    wait_done(1, 20, "b_held_end");

    while (!rnd_done) @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
